decode_stage_hs: RTL

Parametrised RV32I decode stage with a valid/ready-handshaked ID/EX pipeline register. It reads the register file, builds immediates, selects the ALU and compare operands, and registers the result towards EX. Over the previous decode stage it adds backpressure stall, flush, a load-use interlock, WB-to-ID bypass and illegal-opcode flagging. It sits between the fetch stage and the execute stage.

---
 rtl/decode_stage_hs_pkg.sv | 56 +++++
 rtl/decode_stage_hs_control_rom.sv | 70 +++++++
 rtl/decode_stage_hs_regfile.sv | 37 +++
 rtl/decode_stage_hs.sv | 129 ++++++++++++
 4 files changed

// File: rtl/decode_stage_hs_pkg.sv
// RV32I decode types: control word, operand-mux selects, opcode map and
// per-opcode source-register usage tables.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [6:0] {
        OpLui   = 7'b0110111,
        OpAuipc = 7'b0010111,
        OpJal   = 7'b1101111,
        OpJalr  = 7'b1100111,
        OpBr    = 7'b1100011,
        OpLoad  = 7'b0000011,
        OpStore = 7'b0100011,
        OpImm   = 7'b0010011,
        OpReg   = 7'b0110011,
        OpFence = 7'b0001111,
        OpSys   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic {Alu1Rs1, Alu1Pc} alumux1_sel_t;

    typedef enum logic [2:0] {
        Alu2IImm, Alu2UImm, Alu2BImm, Alu2SImm, Alu2JImm, Alu2Rs2
    } alumux2_sel_t;

    typedef enum logic {CmpRs2, CmpIImm} cmpmux_sel_t;

    typedef struct packed {
        logic [6:0]   opcode;
        logic [2:0]   aluop;
        logic         alu_alt;
        logic [2:0]   cmpop;
        logic         load_regfile;
        logic         mem_read;
        logic         mem_write;
        logic         is_load;
        alumux1_sel_t alumux1_sel;
        alumux2_sel_t alumux2_sel;
        cmpmux_sel_t  cmpmux_sel;
    } rv32i_control_word;

    function automatic logic is_rv32i_op(input logic [6:0] op);
        return op inside {OpLui, OpAuipc, OpJal, OpJalr, OpBr, OpLoad, OpStore,
                          OpImm, OpReg, OpFence, OpSys};
    endfunction

    function automatic logic rs1_used(input logic [6:0] op);
        return op inside {OpJalr, OpBr, OpLoad, OpStore, OpImm, OpReg};
    endfunction

    function automatic logic rs2_used(input logic [6:0] op);
        return op inside {OpBr, OpStore, OpReg};
    endfunction

endpackage

// File: rtl/decode_stage_hs_control_rom.sv
// Opcode-driven control ROM; unknown opcodes produce an all-zero word.
module rv32i_control_rom
    import rv32i_types::*;
(
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    output rv32i_control_word ctrl
);

    always_comb begin
        ctrl = '0;
        if (is_rv32i_op(opcode)) ctrl.opcode = opcode;
        case (opcode)
            OpLui: begin
                ctrl.load_regfile = 1'b1;
                ctrl.alumux2_sel  = Alu2UImm;
            end
            OpAuipc: begin
                ctrl.load_regfile = 1'b1;
                ctrl.alumux1_sel  = Alu1Pc;
                ctrl.alumux2_sel  = Alu2UImm;
            end
            OpJal: begin
                ctrl.load_regfile = 1'b1;
                ctrl.alumux1_sel  = Alu1Pc;
                ctrl.alumux2_sel  = Alu2JImm;
            end
            OpJalr: begin
                ctrl.load_regfile = 1'b1;
                ctrl.alumux2_sel  = Alu2IImm;
            end
            OpBr: begin
                ctrl.alumux1_sel = Alu1Pc;
                ctrl.alumux2_sel = Alu2BImm;
                ctrl.cmpop       = funct3;
                ctrl.cmpmux_sel  = CmpRs2;
            end
            OpLoad: begin
                ctrl.load_regfile = 1'b1;
                ctrl.mem_read     = 1'b1;
                ctrl.is_load      = 1'b1;
                ctrl.alumux2_sel  = Alu2IImm;
            end
            OpStore: begin
                ctrl.mem_write   = 1'b1;
                ctrl.alumux2_sel = Alu2SImm;
            end
            OpImm: begin
                ctrl.load_regfile = 1'b1;
                ctrl.aluop        = funct3;
                // Only srai carries funct7[5]; elsewhere those bits are immediate.
                ctrl.alu_alt      = (funct3 == 3'b101) && funct7_5;
                ctrl.cmpop        = funct3;
                ctrl.cmpmux_sel   = CmpIImm;
                ctrl.alumux2_sel  = Alu2IImm;
            end
            OpReg: begin
                ctrl.load_regfile = 1'b1;
                ctrl.aluop        = funct3;
                ctrl.alu_alt      = funct7_5;
                ctrl.cmpop        = funct3;
                ctrl.cmpmux_sel   = CmpRs2;
                ctrl.alumux2_sel  = Alu2Rs2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage_hs_regfile.sv
// Parametrised register file, x0 hardwired to zero, optional WB-to-read bypass.
module regfile_p #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREGS     = 32,
    parameter bit          WB_BYPASS = 1'b1,
    localparam int unsigned RA_W     = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [RA_W-1:0] rd,
    input  logic [XLEN-1:0] wdata,
    input  logic [RA_W-1:0] src_a,
    input  logic [RA_W-1:0] src_b,
    output logic [XLEN-1:0] reg_a,
    output logic [XLEN-1:0] reg_b
);

    logic [XLEN-1:0] mem [NREGS];
    logic            hit_a;
    logic            hit_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (load && rd != '0) begin
            mem[rd] <= wdata;
        end
    end

    assign hit_a = WB_BYPASS && load && rd != '0 && rd == src_a;
    assign hit_b = WB_BYPASS && load && rd != '0 && rd == src_b;

    assign reg_a = (src_a == '0) ? '0 : (hit_a ? wdata : mem[src_a]);
    assign reg_b = (src_b == '0) ? '0 : (hit_b ? wdata : mem[src_b]);

endmodule

// File: rtl/decode_stage_hs.sv
// RV32I decode stage with a valid/ready ID/EX register, load-use interlock,
// flush, WB bypass and illegal-opcode flagging.
module decode_stage_hs
    import rv32i_types::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREGS     = 32,
    parameter bit          WB_BYPASS = 1'b1,
    localparam int unsigned RA_W     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [XLEN-1:0]   if_pc,
    input  rv32i_word         if_instr,
    input  logic              wb_load,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output rv32i_word         ex_instr,
    output rv32i_control_word ex_ctrl,
    output logic [XLEN-1:0]   ex_alu_a,
    output logic [XLEN-1:0]   ex_alu_b,
    output logic [XLEN-1:0]   ex_cmp_b,
    output logic [XLEN-1:0]   ex_rs1,
    output logic [XLEN-1:0]   ex_rs2,
    output logic              ex_illegal
);

    logic [RA_W-1:0]   src_a, src_b, ex_rd;
    logic [XLEN-1:0]   rs1_val, rs2_val;
    logic [XLEN-1:0]   i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [XLEN-1:0]   alu_a, alu_b, cmp_b;
    rv32i_control_word rom_ctrl, ctrl;
    logic              illegal, advance, hz;

    assign src_a = if_instr[15 +: RA_W];
    assign src_b = if_instr[20 +: RA_W];
    assign ex_rd = ex_instr[7 +: RA_W];

    regfile_p #(
        .XLEN      (XLEN),
        .NREGS     (NREGS),
        .WB_BYPASS (WB_BYPASS)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .load  (wb_load),
        .rd    (wb_rd),
        .wdata (wb_data),
        .src_a (src_a),
        .src_b (src_b),
        .reg_a (rs1_val),
        .reg_b (rs2_val)
    );

    rv32i_control_rom u_rom (
        .opcode   (if_instr[6:0]),
        .funct3   (if_instr[14:12]),
        .funct7_5 (if_instr[30]),
        .ctrl     (rom_ctrl)
    );

    assign illegal = !is_rv32i_op(if_instr[6:0]);
    assign ctrl    = illegal ? '0 : rom_ctrl;

    assign i_imm = XLEN'($signed(if_instr[31:20]));
    assign s_imm = XLEN'($signed({if_instr[31:25], if_instr[11:7]}));
    assign b_imm = XLEN'($signed({if_instr[31], if_instr[7], if_instr[30:25],
                                  if_instr[11:8], 1'b0}));
    assign u_imm = XLEN'($signed({if_instr[31:12], 12'h000}));
    assign j_imm = XLEN'($signed({if_instr[31], if_instr[19:12], if_instr[20],
                                  if_instr[30:21], 1'b0}));

    always_comb begin
        alu_a = (ctrl.alumux1_sel == Alu1Pc) ? if_pc : rs1_val;
        case (ctrl.alumux2_sel)
            Alu2IImm: alu_b = i_imm;
            Alu2UImm: alu_b = u_imm;
            Alu2BImm: alu_b = b_imm;
            Alu2SImm: alu_b = s_imm;
            Alu2JImm: alu_b = j_imm;
            default:  alu_b = rs2_val;
        endcase
        cmp_b = (ctrl.cmpmux_sel == CmpIImm) ? i_imm : rs2_val;
    end

    assign advance = !ex_valid || ex_ready;
    assign hz = ex_valid && ex_ctrl.is_load && ex_rd != '0 &&
                ((rs1_used(if_instr[6:0]) && ex_rd == src_a) ||
                 (rs2_used(if_instr[6:0]) && ex_rd == src_b));
    // Flush always drains fetch so the redirected stream can start next cycle.
    assign if_ready = flush || (advance && !hz);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_instr   <= '0;
            ex_ctrl    <= '0;
            ex_alu_a   <= '0;
            ex_alu_b   <= '0;
            ex_cmp_b   <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_illegal <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (advance && if_valid && !hz) begin
            ex_valid   <= 1'b1;
            ex_pc      <= if_pc;
            ex_instr   <= if_instr;
            ex_ctrl    <= ctrl;
            ex_alu_a   <= alu_a;
            ex_alu_b   <= alu_b;
            ex_cmp_b   <= cmp_b;
            ex_rs1     <= rs1_val;
            ex_rs2     <= rs2_val;
            ex_illegal <= illegal;
        end else if (advance) begin
            ex_valid <= 1'b0;
        end
    end

endmodule
